// File: rtl/board_input_conditioner_if.sv
// Pin-side bundle for board_input_conditioner: raw buttons/switches in,
// debounced levels and edge pulses out.
interface board_input_conditioner_if #(
  parameter int N_SW  = 10,
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_i;
  logic [N_SW-1:0]  sw_i;
  logic [N_BTN-1:0] btn_lvl_o;
  logic [N_BTN-1:0] btn_press_o;
  logic [N_BTN-1:0] btn_rel_o;
  logic [N_SW-1:0]  sw_out_o;
  logic             sw_chg_o;

  modport master (
    output btn_i, sw_i,
    input  btn_lvl_o, btn_press_o, btn_rel_o, sw_out_o, sw_chg_o
  );

  modport slave (
    input  btn_i, sw_i,
    output btn_lvl_o, btn_press_o, btn_rel_o, sw_out_o, sw_chg_o
  );
endinterface

// File: rtl/board_input_conditioner.sv
// Synchronises and debounces raw board buttons and switches, producing clean
// levels plus registered press/release pulses and a switch-change strobe.
module board_input_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int N_SW      = 10,
  parameter int N_BTN     = 2
) (
  input logic                      clk1_i,
  input logic                      rst_n_i,
  board_input_conditioner_if.slave pins
);

  localparam int N  = N_SW + N_BTN;
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  // Buttons are active-low on the board, so their sync flops idle high.
  localparam logic [N-1:0]  SYNC_RST = {{N_SW{1'b0}}, {N_BTN{1'b1}}};

  logic [N-1:0]         s1_q, s2_q;
  logic [N-1:0]         cond;
  logic [N-1:0]         st_q, st_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0]     press_q, press_d;
  logic [N_BTN-1:0]     rel_q, rel_d;
  logic                 chg_q, chg_d;

  assign cond = s2_q ^ SYNC_RST;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    for (int b = 0; b < N; b++) begin
      if (cond[b] == st_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_MAX) begin
        st_d[b]  = cond[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_ONE;
      end
    end
  end

  // Pulses are derived from the next state so they land on the same edge as the level.
  always_comb begin
    press_d = st_d[N_BTN-1:0] & ~st_q[N_BTN-1:0];
    rel_d   = ~st_d[N_BTN-1:0] & st_q[N_BTN-1:0];
    chg_d   = |(st_d[N-1:N_BTN] ^ st_q[N-1:N_BTN]);
  end

  always_ff @(posedge clk1_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q    <= SYNC_RST;
      s2_q    <= SYNC_RST;
      st_q    <= '0;
      cnt_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      s1_q    <= {pins.sw_i, pins.btn_i};
      s2_q    <= s1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      chg_q   <= chg_d;
    end
  end

  assign pins.btn_lvl_o   = st_q[N_BTN-1:0];
  assign pins.btn_press_o = press_q;
  assign pins.btn_rel_o   = rel_q;
  assign pins.sw_out_o    = st_q[N-1:N_BTN];
  assign pins.sw_chg_o    = chg_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Self-checking bench for board_input_conditioner: directed scenarios plus a
// randomized run, all compared against a window-based reference model.
module tb_board_input_conditioner;

  localparam int DB    = 4;
  localparam int N_SW  = 10;
  localparam int N_BTN = 2;
  localparam int N     = N_SW + N_BTN;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   total = 0;
  int   bad = 0;

  board_input_conditioner_if #(.N_SW(N_SW), .N_BTN(N_BTN)) pins();

  board_input_conditioner #(
    .DB_CYCLES(DB),
    .N_SW     (N_SW),
    .N_BTN    (N_BTN)
  ) dut (
    .clk1_i (clk),
    .rst_n_i(rstN),
    .pins   (pins)
  );

  always #10 clk = ~clk;

  // Model: conditioned samples (buttons inverted) flow through a two-deep delay;
  // a bit's level flips once the last DB delayed samples all disagree with it.
  logic [N-1:0] mSync[$];
  logic [N-1:0] mSeen[$];
  logic [N-1:0] mLvl;
  logic [1:0]   mPress, mRel;
  logic         mChg;

  function automatic logic [16:0] modelOut();
    return {mLvl[1:0], mPress, mRel, mLvl[11:2], mChg};
  endfunction

  function automatic logic [16:0] dutOut();
    return {pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o, pins.sw_out_o, pins.sw_chg_o};
  endfunction

  task automatic tick();
    logic [N-1:0] seen, newLvl;
    bit           allDiffer;
    @(posedge clk);
    if (!rstN) begin
      mSync = '{12'h000, 12'h000};
      mSeen.delete();
      mLvl = '0; mPress = '0; mRel = '0; mChg = 1'b0;
    end else begin
      seen = mSync.pop_front();
      mSync.push_back({pins.sw_i, ~pins.btn_i});
      mSeen.push_back(seen);
      if (mSeen.size() > DB) void'(mSeen.pop_front());
      newLvl = mLvl;
      for (int b = 0; b < N; b++) begin
        allDiffer = (mSeen.size() == DB);
        foreach (mSeen[j]) if (mSeen[j][b] == mLvl[b]) allDiffer = 1'b0;
        if (allDiffer) newLvl[b] = ~mLvl[b];
      end
      mPress = newLvl[1:0] & ~mLvl[1:0];
      mRel   = ~newLvl[1:0] & mLvl[1:0];
      mChg   = |(newLvl[11:2] ^ mLvl[11:2]);
      mLvl   = newLvl;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstN = 1'b0; pins.btn_i = 2'b00; pins.sw_i = 10'h3FF;
    for (int t = 1; t <= 3; t++) begin
      tick();
      total++;
      if (dutOut() !== 17'h0) begin
        bad++; $display("[TB] FAIL reset_zero t=%0d got=%h exp=%h", t, dutOut(), 17'h0);
      end
    end
    rstN = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      total++;
      if (dutOut() !== modelOut()) begin
        bad++; $display("[TB] FAIL reset_release t=%0d got=%h exp=%h", t, dutOut(), modelOut());
      end
      total++;
      if ({pins.btn_press_o, pins.sw_chg_o} !== ((t == 6) ? 3'b111 : 3'b000)) begin
        bad++; $display("[TB] FAIL held_through_reset t=%0d got=%b exp=%b", t,
                        {pins.btn_press_o, pins.sw_chg_o}, (t == 6) ? 3'b111 : 3'b000);
      end
    end
    pins.btn_i = 2'b11; pins.sw_i = 10'h000;
    for (int t = 1; t <= 8; t++) begin
      tick();
      total++;
      if (dutOut() !== modelOut()) begin
        bad++; $display("[TB] FAIL reset_settle t=%0d got=%h exp=%h", t, dutOut(), modelOut());
      end
    end
  endtask

  task automatic test_stable_press();
    logic [5:0] exp;
    pins.btn_i = 2'b10;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp = {(t >= 6) ? 2'b01 : 2'b00, (t == 6) ? 2'b01 : 2'b00, 2'b00};
      total++;
      if ({pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o} !== exp) begin
        bad++; $display("[TB] FAIL press t=%0d got=%b exp=%b", t,
                        {pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o}, exp);
      end
    end
    pins.btn_i = 2'b11;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp = {(t >= 6) ? 2'b00 : 2'b01, 2'b00, (t == 6) ? 2'b01 : 2'b00};
      total++;
      if ({pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o} !== exp) begin
        bad++; $display("[TB] FAIL release t=%0d got=%b exp=%b", t,
                        {pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [5:0] exp;
    for (int t = 1; t <= 11; t++) begin
      pins.btn_i = (t <= 3) ? 2'b10 : 2'b11;
      tick();
      total++;
      if ({pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o} !== 6'b0) begin
        bad++; $display("[TB] FAIL glitch3 t=%0d got=%b exp=%b", t,
                        {pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o}, 6'b0);
      end
    end
    for (int t = 1; t <= 14; t++) begin
      pins.btn_i = (t <= 4) ? 2'b10 : 2'b11;
      tick();
      exp = {(t >= 6 && t < 10) ? 2'b01 : 2'b00, (t == 6) ? 2'b01 : 2'b00,
             (t == 10) ? 2'b01 : 2'b00};
      total++;
      if ({pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o} !== exp) begin
        bad++; $display("[TB] FAIL glitch4 t=%0d got=%b exp=%b", t,
                        {pins.btn_lvl_o, pins.btn_press_o, pins.btn_rel_o}, exp);
      end
    end
  endtask

  task automatic test_switch_pattern();
    logic [10:0] exp;
    int          pulses = 0;
    pins.sw_i = 10'h035;
    for (int t = 1; t <= 10; t++) begin
      tick();
      pulses += int'(pins.sw_chg_o);
      exp = {(t >= 6) ? 10'h035 : 10'h000, t == 6};
      total++;
      if ({pins.sw_out_o, pins.sw_chg_o} !== exp) begin
        bad++; $display("[TB] FAIL sw_first t=%0d got=%h exp=%h", t, {pins.sw_out_o, pins.sw_chg_o}, exp);
      end
    end
    pins.sw_i = 10'h04A;
    for (int t = 1; t <= 12; t++) begin
      tick();
      pulses += int'(pins.sw_chg_o);
      exp = {(t >= 6) ? 10'h04A : 10'h035, t == 6};
      total++;
      if ({pins.sw_out_o, pins.sw_chg_o} !== exp) begin
        bad++; $display("[TB] FAIL sw_second t=%0d got=%h exp=%h", t, {pins.sw_out_o, pins.sw_chg_o}, exp);
      end
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("[TB] FAIL sw_chg_count got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp;
    pins.sw_i = 10'h000;
    for (int t = 1; t <= 10; t++) tick();
    total++;
    if (dutOut() !== modelOut()) begin
      bad++; $display("[TB] FAIL simul_settle got=%h exp=%h", dutOut(), modelOut());
    end
    pins.sw_i = 10'h07F; pins.btn_i = 2'b00;
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp = (t == 6) ? 3'b111 : 3'b000;
      total++;
      if ({pins.btn_press_o, pins.sw_chg_o} !== exp) begin
        bad++; $display("[TB] FAIL simul_pulse t=%0d got=%b exp=%b", t, {pins.btn_press_o, pins.sw_chg_o}, exp);
      end
      total++;
      if (dutOut() !== modelOut()) begin
        bad++; $display("[TB] FAIL simul_model t=%0d got=%h exp=%h", t, dutOut(), modelOut());
      end
    end
    pins.btn_i = 2'b11; pins.sw_i = 10'h000;
    for (int t = 1; t <= 9; t++) begin
      tick();
      total++;
      if (dutOut() !== modelOut()) begin
        bad++; $display("[TB] FAIL simul_release t=%0d got=%h exp=%h", t, dutOut(), modelOut());
      end
    end
  endtask

  task automatic test_reset_mid_count();
    pins.sw_i = 10'h008;
    for (int t = 1; t <= 4; t++) tick();
    rstN = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      total++;
      if (pins.sw_out_o !== 10'h000) begin
        bad++; $display("[TB] FAIL mid_reset_hold t=%0d got=%h exp=%h", t, pins.sw_out_o, 10'h000);
      end
    end
    rstN = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      total++;
      if (pins.sw_out_o[3] !== (t >= 6)) begin
        bad++; $display("[TB] FAIL mid_reset_restart t=%0d got=%b exp=%b", t, pins.sw_out_o[3], t >= 6);
      end
      total++;
      if (dutOut() !== modelOut()) begin
        bad++; $display("[TB] FAIL mid_reset_model t=%0d got=%h exp=%h", t, dutOut(), modelOut());
      end
    end
  endtask

  task automatic test_random();
    int hold;
    int cyc = 0;
    while (cyc < 500) begin
      if ($urandom_range(0, 39) == 0) begin
        rstN = 1'b0;
        #1;
        total++;
        if (dutOut() !== 17'h0) begin
          bad++; $display("[TB] FAIL rand_async_reset cyc=%0d got=%h exp=%h", cyc, dutOut(), 17'h0);
        end
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) tick();
        rstN = 1'b1;
      end
      pins.btn_i = 2'($urandom);
      pins.sw_i  = pins.sw_i ^ (10'($urandom) & 10'($urandom) & 10'($urandom));
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        tick();
        cyc++;
        total++;
        if (dutOut() !== modelOut()) begin
          bad++; $display("[TB] FAIL rand_model cyc=%0d got=%h exp=%h", cyc, dutOut(), modelOut());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stable_press();
    test_glitch();
    test_switch_pattern();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
